// File: rtl/cam_lookup_scheduler.sv
// cam_lookup_scheduler: queues lookup keys, issues them to a registered CAM
// through a two-stage tag pipeline, and returns {key, addr, hit, count}
// responses in acceptance order. Issue is credit-gated so that every key in
// flight always has a reserved slot in the response FIFO.
module cam_lookup_scheduler #(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_key,
  output logic [15:0] cam_key,
  input  logic [2:0]  cam_addr,
  input  logic        cam_hit,
  input  logic [3:0]  cam_count,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_key,
  output logic [2:0]  rsp_addr,
  output logic        rsp_hit,
  output logic [3:0]  rsp_count,
  output logic [1:0]  inflight
);

  localparam int IW  = $clog2(IN_DEPTH);
  localparam int OW  = $clog2(OUT_DEPTH);
  localparam int ICW = IW + 1;
  localparam int OCW = OW + 1;
  localparam int SW  = OW + 2;

  localparam logic [ICW-1:0] IN_FULL = ICW'(IN_DEPTH);
  localparam logic [SW-1:0]  OUT_CAP = SW'(OUT_DEPTH);

  logic [15:0]    in_mem [IN_DEPTH];
  logic [IW-1:0]  in_wr, in_rd;
  logic [ICW-1:0] in_cnt;

  logic [23:0]    out_mem [OUT_DEPTH];
  logic [OW-1:0]  out_wr, out_rd;
  logic [OCW-1:0] out_cnt;

  logic           run;
  logic           s1_v, s2_v;
  logic [15:0]    s1_key, s2_key;

  logic           in_push, issue, out_pop;
  logic [SW-1:0]  used;

  // run stays low until the first edge out of reset, holding req_ready low
  // through reset without a combinational path from the reset pin.
  assign req_ready = run && (in_cnt < IN_FULL);
  assign in_push   = req_valid && req_ready;
  assign inflight  = {1'b0, s1_v} + {1'b0, s2_v};

  // Credit counts response slots already filled plus those reserved by
  // lookups in the pipeline; it is taken from pre-edge state only.
  assign used      = SW'(out_cnt) + SW'(inflight);
  assign issue     = (in_cnt != '0) && (used < OUT_CAP);

  assign rsp_valid = (out_cnt != '0);
  assign out_pop   = rsp_valid && rsp_ready;
  assign {rsp_key, rsp_addr, rsp_hit, rsp_count} = rsp_valid ? out_mem[out_rd] : 24'h0;

  // Ready enable, set on the first edge after reset is released
  always_ff @(posedge clk or posedge reset) begin
    if (reset) run <= 1'b0;
    else       run <= 1'b1;
  end

  // Request FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_wr  <= '0;
      in_rd  <= '0;
      in_cnt <= '0;
    end else begin
      if (in_push) in_wr <= in_wr + IW'(1);
      if (issue)   in_rd <= in_rd + IW'(1);
      case ({in_push, issue})
        2'b10:   in_cnt <= in_cnt + ICW'(1);
        2'b01:   in_cnt <= in_cnt - ICW'(1);
        default: in_cnt <= in_cnt;
      endcase
    end
  end

  // Request FIFO storage
  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr] <= req_key;
  end

  // Issue to the CAM and carry the key alongside the two-cycle CAM latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cam_key <= 16'h0000;
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      s1_key  <= 16'h0000;
      s2_key  <= 16'h0000;
    end else begin
      s1_v   <= issue;
      s2_v   <= s1_v;
      s2_key <= s1_key;
      if (issue) begin
        cam_key <= in_mem[in_rd];
        s1_key  <= in_mem[in_rd];
      end
    end
  end

  // Response FIFO pointers and occupancy; S2 pushes the CAM result it sees now
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_wr  <= '0;
      out_rd  <= '0;
      out_cnt <= '0;
    end else begin
      if (s2_v)    out_wr <= out_wr + OW'(1);
      if (out_pop) out_rd <= out_rd + OW'(1);
      case ({s2_v, out_pop})
        2'b10:   out_cnt <= out_cnt + OCW'(1);
        2'b01:   out_cnt <= out_cnt - OCW'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // Response FIFO storage
  always_ff @(posedge clk) begin
    if (s2_v) out_mem[out_wr] <= {s2_key, cam_addr, cam_hit, cam_count};
  end

endmodule

// File: tb/tb_cam_lookup_scheduler.sv
// Bench for cam_lookup_scheduler: registered CAM model, scoreboard queue of
// expected responses filled on request acceptance, monitor that pops on every
// response transfer, plus directed latency/backpressure/reset scenarios and a
// long random run.
module tb_cam_lookup_scheduler;

  localparam int IN_DEPTH  = 4;
  localparam int OUT_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [15:0] req_key, cam_key;
  logic [2:0]  cam_addr;
  logic        cam_hit;
  logic [3:0]  cam_count;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_key;
  logic [2:0]  rsp_addr;
  logic        rsp_hit;
  logic [3:0]  rsp_count;
  logic [1:0]  inflight;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] cam_mem [8];
  logic [23:0] exp_q [$];
  logic        armed = 1'b0;
  logic        prev_stall = 1'b0;
  logic [23:0] prev_rsp = '0;

  always #5 clk = ~clk;

  cam_lookup_scheduler #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .cam_key(cam_key), .cam_addr(cam_addr), .cam_hit(cam_hit), .cam_count(cam_count),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_key(rsp_key), .rsp_addr(rsp_addr), .rsp_hit(rsp_hit), .rsp_count(rsp_count),
    .inflight(inflight)
  );

  // Reference CAM lookup: highest matching index, any-match flag, match count
  function automatic logic [7:0] cam_eval(input logic [15:0] k);
    int n  = 0;
    int hi = 0;
    for (int i = 0; i < 8; i++)
      if (cam_mem[i] == k) begin
        n++;
        hi = i;
      end
    return {3'(hi), (n != 0), 4'(n)};
  endfunction

  // Registered CAM: result appears one edge after the key it was computed from
  always @(posedge clk) {cam_addr, cam_hit, cam_count} <= cam_eval(cam_key);

  always @(posedge clk) armed <= !reset;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: invariants, response scoreboard, and capture of accepted keys
  always @(negedge clk) begin
    logic [23:0] cur;
    cur = {rsp_key, rsp_addr, rsp_hit, rsp_count};
    if (reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("rsp_stable", cur, prev_rsp);
      if (exp_q.size() == 0) chk("rsp_valid_when_empty", rsp_valid, 0);
      if (exp_q.size() >= IN_DEPTH + OUT_DEPTH) chk("ready_when_full", req_ready, 0);
      if (armed && exp_q.size() < IN_DEPTH) chk("ready_when_room", req_ready, 1);
      chk("inflight_bound", (inflight <= 2) && (inflight <= exp_q.size()), 1);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rsp: actual=%0h required=none at %0t", cur, $time);
        end else begin
          chk("rsp_order_content", cur, exp_q.pop_front());
        end
      end
      if (req_valid && req_ready) exp_q.push_back({req_key, cam_eval(req_key)});
      prev_stall = rsp_valid && !rsp_ready;
      prev_rsp   = cur;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while ((exp_q.size() != 0 || rsp_valid || inflight != 0) && t < 300) begin
      step();
      t++;
    end
    chk(nm, (t < 300), 1);
  endtask

  task automatic send_and_check(input string nm, input logic [15:0] k, input logic [23:0] exp);
    int t = 0;
    req_key   = k;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    while (!rsp_valid && t < 10) begin
      step();
      t++;
    end
    chk(nm, rsp_valid ? {rsp_key, rsp_addr, rsp_hit, rsp_count} : 24'hFFFFFF, exp);
    wait_idle({nm, "_drain"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] vmask, emask;
    int acc, t;

    reset = 1'b1; req_valid = 1'b0; req_key = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) cam_mem[i] = 16'(i);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_cam_key", cam_key, 0);
    chk("rst_rsp_fields", {rsp_key, rsp_addr, rsp_hit, rsp_count}, 0);
    reset = 1'b0;
    step();
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_rsp_valid", rsp_valid, 0);

    // Minimum latency of a single hit
    rsp_ready = 1'b1;
    req_key = 16'h0005; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("lat_a0_valid", rsp_valid, 0);
    chk("lat_a0_inflight", inflight, 0);
    step();
    chk("lat_a1_cam_key", cam_key, 16'h0005);
    chk("lat_a1_inflight", inflight, 1);
    step();
    chk("lat_a2_valid", rsp_valid, 0);
    chk("lat_a2_inflight", inflight, 1);
    step();
    chk("lat_a3_valid", rsp_valid, 1);
    chk("lat_a3_inflight", inflight, 0);
    chk("lat_a3_rsp", {rsp_key, rsp_addr, rsp_hit, rsp_count}, {16'h0005, 3'd5, 1'b1, 4'd1});
    step();
    chk("lat_a4_valid", rsp_valid, 0);
    chk("lat_cam_key_hold", cam_key, 16'h0005);

    // Miss, then a double match reporting the highest index
    send_and_check("miss_key9", 16'h0009, {16'h0009, 3'd0, 1'b0, 4'd0});
    cam_mem[2] = 16'h00AA; cam_mem[6] = 16'h00AA;
    send_and_check("multi_hit_aa", 16'h00AA, {16'h00AA, 3'd6, 1'b1, 4'd2});
    cam_mem[2] = 16'h0002; cam_mem[6] = 16'h0006;

    // Back-to-back stream: eight responses on eight consecutive cycles
    vmask = '0;
    emask = '0;
    for (int c = 3; c <= 10; c++) emask[c] = 1'b1;
    for (int c = 0; c < 14; c++) begin
      req_valid = (c < 8);
      req_key   = 16'(c);
      step();
      vmask[c] = rsp_valid;
    end
    req_valid = 1'b0;
    chk("stream_valid_run", vmask, emask);
    wait_idle("stream_drain");

    // Backpressure: 12 offered, buffering limited to IN_DEPTH + OUT_DEPTH
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      logic will;
      req_valid = 1'b1;
      req_key   = 16'((acc * 5) % 16);
      will      = req_ready;
      step();
      if (will) acc++;
    end
    chk("bp_accepted", acc, IN_DEPTH + OUT_DEPTH);
    chk("bp_ready_low", req_ready, 0);
    chk("bp_inflight", inflight, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    t = 0;
    while (acc < 12 && t < 40) begin
      logic will;
      req_valid = 1'b1;
      req_key   = 16'((acc * 5) % 16);
      will      = req_ready;
      step();
      if (will) acc++;
      t++;
    end
    req_valid = 1'b0;
    chk("bp_rest_accepted", acc, 12);
    wait_idle("bp_drain");

    // Reset with lookups queued, in flight, and buffered
    rsp_ready = 1'b0;
    t = 0;
    req_valid = 1'b1;
    while (!(inflight == 2 && rsp_valid) && t < 20) begin
      req_key = 16'(t + 1);
      step();
      t++;
    end
    chk("rst_mid_setup", (inflight == 2) && rsp_valid, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_req_ready", req_ready, 0);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_inflight", inflight, 0);
    chk("rst_mid_cam_key", cam_key, 0);
    chk("rst_mid_rsp_fields", {rsp_key, rsp_addr, rsp_hit, rsp_count}, 0);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    chk("rst_mid_post_ready", req_ready, 1);
    rsp_ready = 1'b1;
    repeat (10) step();
    chk("rst_mid_no_stale", rsp_valid, 0);

    // Random traffic against the scoreboard
    for (int c = 0; c < 10000; c++) begin
      req_valid = ($urandom_range(0, 99) < 60);
      req_key   = 16'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 99) < 55);
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle("random_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cam_lookup_scheduler.md
CAM_LOOKUP_SCHEDULER -- requirements
Module: cam_lookup_scheduler

Interface
REQ-001 Parameter: IN_DEPTH, default 4, request FIFO entries; power of two, minimum 2.
REQ-002 Parameter: OUT_DEPTH, default 4, response FIFO entries; power of two, minimum 2.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 req_valid  in  1  upstream offers a lookup key.
REQ-006 req_ready  out  1  block can accept a key this cycle.
REQ-007 req_key  in  16  key to look up.
REQ-008 cam_key  out  16  registered key driven to the CAM data_lookup port.
REQ-009 cam_addr  in  3  CAM registered highest matching index.
REQ-010 cam_hit  in  1  CAM registered valid (at least one match).
REQ-011 cam_count  in  4  CAM registered match count, 0..8.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  downstream consumes the response.
REQ-014 rsp_key, rsp_addr, rsp_hit, rsp_count  out  16/3/1/4  head response: original key plus CAM result.
REQ-015 inflight  out  2  number of keys issued to the CAM and not yet captured, 0..2.

Function
REQ-016 A request transfers on an edge where req_valid=1 and req_ready=1; a response transfers on an edge where rsp_valid=1 and rsp_ready=1.
REQ-017 req_ready = (request FIFO count < IN_DEPTH), derived from registered state only; no combinational path from rsp_ready or issue logic.
REQ-018 Issue condition at an edge: request FIFO non-empty AND credit > 0, where credit = OUT_DEPTH - response FIFO count - inflight, evaluated from pre-edge state (no lookahead on same-cycle pops).
REQ-019 On issue: cam_key <= request FIFO head, head popped, issue tag set in pipeline stage S1 together with the key copy.
REQ-020 Stage S1 advances to S2 on the next edge unconditionally; on the following edge S2 captures {key, cam_addr, cam_hit, cam_count} into the response FIFO (CAM result is valid exactly two edges after cam_key update).
REQ-021 At most one issue per cycle; back-to-back issues on consecutive edges are allowed, sustaining one lookup per cycle.
REQ-022 cam_key holds its last value when not issuing.
REQ-023 inflight = count of S1 and S2 tags set.
REQ-024 Minimum latency: key accepted at edge A -> issued at A+1 -> captured at A+3 -> rsp_valid=1 in the cycle after A+3.
REQ-025 Responses leave in request-acceptance order; no reordering, no drops, no duplicates.
REQ-026 Simultaneous push and pop on either FIFO in one cycle are legal; count unchanged, pointers both advance.
REQ-027 Push into a full FIFO never occurs (req_ready=0; credit prevents response overflow); pop of an empty FIFO never occurs (rsp_valid=0).
REQ-028 FIFO read/write pointers wrap modulo depth; counts are width clog2(depth)+1 and never exceed depth.
REQ-029 rsp_valid = (response FIFO count != 0); rsp_* fields are the head entry and stable while rsp_valid=1 and rsp_ready=0.
REQ-030 CAM contents changing while a key is in flight is permitted; the captured result is whatever the CAM presents at capture.

Reset
REQ-031 While reset=1: req_ready=0, rsp_valid=0, inflight=0, cam_key=16'h0000, rsp_* fields=0, all counts, pointers and stage tags cleared.
REQ-032 Reset mid-operation discards all queued and in-flight lookups; no response for them is ever produced.
REQ-033 First edge after reset deassertion: req_ready=1, all FIFOs empty.

Verification (bench uses a CAM model holding entries 0..7 = values 0x0000..0x0007)
REQ-034 Single key 0x0005, rsp_ready=1 -> rsp_key=0x0005, rsp_addr=5, rsp_hit=1, rsp_count=1, rsp_valid rising 3 edges after acceptance.
REQ-035 Key 0x0009 -> rsp_hit=0, rsp_addr=0, rsp_count=0; model with entries 2 and 6 both 0x00AA, key 0x00AA -> addr=6, hit=1, count=2.
REQ-036 Stream keys 0..7 on 8 consecutive edges, rsp_ready=1 -> 8 responses on 8 consecutive cycles, addr=key[2:0], in order.
REQ-037 rsp_ready=0, push 12 keys -> exactly OUT_DEPTH+IN_DEPTH=8 accepted, req_ready=0 thereafter, inflight=0, response FIFO full; release rsp_ready -> all 8 drain in order, then remaining keys accepted.
REQ-038 Assert reset with inflight=2 and both FIFOs non-empty -> outputs per REQ-031 immediately; after release no stale response appears.
REQ-039 Random req_valid/rsp_ready 10,000 cycles against scoreboard -> order, content and credit invariants (count+inflight <= OUT_DEPTH) hold every cycle.
